// File: rtl/pq_pkg.sv
// Shared definitions for the PQ accelerator cluster: the sampler-sequencer state
// encoding, the modulus and the binomial sampler mode codes.
package pq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } binom_ctrl_state_t;

  localparam int PARAM_Q = 12289;

  localparam logic [1:0] BINOM_ETA2  = 2'b00;
  localparam logic [1:0] BINOM_ETA4  = 2'b01;
  localparam logic [1:0] BINOM_ETA8  = 2'b10;
  localparam logic [1:0] BINOM_ETA16 = 2'b11;

endpackage

// File: rtl/binom_poly_sampler_ctrl_if.sv
// Random-word input stream and coefficient write port of the binomial sampler
// sequencer; master is the sequencer, slave is the surrounding fabric.
interface binom_poly_sampler_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                    rnd_valid;
  logic                    rnd_ready;
  logic [2*DATA_WIDTH-1:0] rnd_data;
  logic                    coef_valid;
  logic                    coef_ready;
  logic [ADDR_WIDTH-1:0]   coef_addr;
  logic [2*DATA_WIDTH-1:0] coef_data;

  modport master (
    input  rnd_valid, rnd_data, coef_ready,
    output rnd_ready, coef_valid, coef_addr, coef_data
  );

  modport slave (
    output rnd_valid, rnd_data, coef_ready,
    input  rnd_ready, coef_valid, coef_addr, coef_data
  );
endinterface

// File: rtl/binom_sample.sv
// Combinational centred-binomial sampler: popcount(in_1) - popcount(in_2) over the
// low 2/4/8/16 bits selected by mode, returned as a residue in [0, PARAM_Q).
module binom_sample #(
  parameter int DATA_WIDTH = 16,
  parameter int PARAM_Q    = 12289
) (
  input  logic [DATA_WIDTH-1:0]   in_1,
  input  logic [DATA_WIDTH-1:0]   in_2,
  input  logic [1:0]              mode,
  output logic [2*DATA_WIDTH-1:0] result
);
  import pq_pkg::*;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic signed [2*DATA_WIDTH-1:0] QW = (2*DATA_WIDTH)'(PARAM_Q);

  function automatic int op_bits(input logic [1:0] m);
    case (m)
      BINOM_ETA2: return 2;
      BINOM_ETA4: return 4;
      BINOM_ETA8: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [DATA_WIDTH-1:0] v, input logic [1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i < op_bits(m)) c = c + CW'(v[i]);
    return c;
  endfunction

  // Negative differences fold into the upper end of the residue range.
  function automatic logic [2*DATA_WIDTH-1:0] mod_q(input logic signed [CW:0] d);
    logic signed [2*DATA_WIDTH-1:0] w;
    w = {{(2*DATA_WIDTH-CW-1){d[CW]}}, d};
    if (w < 0) w = w + QW;
    return $unsigned(w);
  endfunction

  logic signed [CW:0] diff;

  always_comb begin
    diff   = $signed({1'b0, popcnt(in_1, mode)}) - $signed({1'b0, popcnt(in_2, mode)});
    result = mod_q(diff);
  end

endmodule

// File: rtl/binom_poly_sampler_ctrl.sv
// Fills one polynomial with centred-binomial coefficients: one random word per
// coefficient in, one registered RAM write per coefficient out, consecutive addresses.
module binom_poly_sampler_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N_COEFF    = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int PARAM_Q    = pq_pkg::PARAM_Q
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  binom_poly_sampler_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done
);
  import pq_pkg::*;

  localparam int CNT_W = $clog2(N_COEFF) + 1;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_COEFF - 1);
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(N_COEFF);

  binom_ctrl_state_t state, state_nxt;

  logic [1:0]              mode_lat;
  logic [ADDR_WIDTH-1:0]   base_lat;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        write_cnt;
  logic [2*DATA_WIDTH-1:0] smp_res;
  logic [2*DATA_WIDTH-1:0] data_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic                    vld_p1;
  logic                    in_hs;
  logic                    wr_hs;
  logic                    go;

  assign in_hs = bus.rnd_valid && bus.rnd_ready;
  assign wr_hs = vld_p1 && bus.coef_ready;
  assign go    = (state == ST_IDLE) && start && !abort;

  binom_sample #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARAM_Q    (PARAM_Q)
  ) u_sample (
    .in_1   (bus.rnd_data[DATA_WIDTH-1:0]),
    .in_2   (bus.rnd_data[2*DATA_WIDTH-1:DATA_WIDTH]),
    .mode   (mode_lat),
    .result (smp_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_RUN;
        ST_RUN:   if ((in_hs && issue_cnt == N_LAST) || issue_cnt == N_FULL) state_nxt = ST_DRAIN;
        ST_DRAIN: if (wr_hs && write_cnt == N_LAST) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // A word is only taken when the output register is empty or draining this cycle.
  always_comb begin
    bus.rnd_ready = (state == ST_RUN) && !abort && (!vld_p1 || bus.coef_ready)
                    && (issue_cnt < N_FULL);
    busy          = (state == ST_RUN) || (state == ST_DRAIN);
    done          = (state == ST_DONE);
  end

  // Stage p1: registered coefficient, held while the RAM stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_lat  <= '0;
      base_lat  <= '0;
      issue_cnt <= '0;
      write_cnt <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      addr_p1   <= '0;
    end else begin
      if (go) begin
        mode_lat  <= mode;
        base_lat  <= base_addr;
        issue_cnt <= '0;
        write_cnt <= '0;
      end
      if (in_hs) begin
        issue_cnt <= issue_cnt + 1'b1;
        data_p1   <= smp_res;
        addr_p1   <= base_lat + ADDR_WIDTH'(issue_cnt);
      end
      if (wr_hs) write_cnt <= write_cnt + 1'b1;
      if (abort)      vld_p1 <= 1'b0;
      else if (in_hs) vld_p1 <= 1'b1;
      else if (wr_hs) vld_p1 <= 1'b0;
    end
  end

  assign bus.coef_valid = vld_p1;
  assign bus.coef_data  = data_p1;
  assign bus.coef_addr  = addr_p1;

endmodule

// File: tb/tb_binom_poly_sampler_ctrl.sv
// Directed bench for binom_poly_sampler_ctrl with a 4-coefficient polynomial:
// sampler values, addressing and wrap, stalls, abort and asynchronous reset.
module tb_binom_poly_sampler_ctrl;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;

  binom_poly_sampler_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  binom_poly_sampler_ctrl #(
    .DATA_WIDTH (DW),
    .N_COEFF    (NC),
    .ADDR_WIDTH (AW),
    .PARAM_Q    (12289)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  int            dc_q[$];
  logic [31:0]   words[4];

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.coef_valid && bus.coef_ready) begin
        wa_q.push_back(bus.coef_addr);
        wd_q.push_back(bus.coef_data);
        wc_q.push_back(cyc_no);
      end
      if (done) dc_q.push_back(cyc_no);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [AW-1:0] b);
    wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete();
    mode = m; base_addr = b; start = 1'b1;
    step();
    start = 1'b0; mode = ~m; base_addr = ~b;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic stream(input int stall_at, input int stall_len, input int abort_wr);
    int wi;
    bit stall, ab, stop;
    logic [AW-1:0] pa;
    logic [31:0] pd;
    wi = 0; stop = 0; pa = '0; pd = '0;
    for (int c = 0; c < 40 && !stop; c++) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      ab    = (abort_wr >= 0) && (wa_q.size() == abort_wr);
      bus.coef_ready = !stall && !ab;
      abort          = ab;
      bus.rnd_valid  = (wi < NC);
      bus.rnd_data   = (wi < NC) ? words[wi] : 32'h0;
      #1;
      if (stall) begin
        chk("stall_rnd_ready", bus.rnd_ready, 0);
        if (c > stall_at) begin
          chk("stall_addr_hold", bus.coef_addr, pa);
          chk("stall_data_hold", bus.coef_data, pd);
        end
      end
      pa = bus.coef_addr; pd = bus.coef_data;
      @(negedge clk);
      if (bus.rnd_valid && bus.rnd_ready) wi++;
      step();
      if (ab || dc_q.size() > 0) stop = 1;
    end
    abort = 1'b0; bus.rnd_valid = 1'b0; bus.coef_ready = 1'b0;
  endtask

  task automatic verify(input string tag, input logic [AW-1:0] b,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] ed[4];
    logic [AW-1:0] ea;
    ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
    chk({tag, "_wr_count"}, wa_q.size(), NC);
    for (int i = 0; i < NC; i++) begin
      if (i < wa_q.size()) begin
        ea = b + AW'(i);
        chk({tag, "_addr"}, wa_q[i], ea);
        chk({tag, "_data"}, wd_q[i], ed[i]);
      end
    end
    chk({tag, "_done_count"}, dc_q.size(), 1);
    if (dc_q.size() > 0 && wc_q.size() == NC)
      chk({tag, "_done_latency"}, dc_q[0], wc_q[NC-1] + 1);
  endtask

  initial begin
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = '0;
    bus.coef_ready = 1'b0;

    // reset state
    step(); step();
    chk("rst_rnd_ready", bus.rnd_ready, 0);
    chk("rst_coef_valid", bus.coef_valid, 0);
    chk("rst_coef_addr", bus.coef_addr, 0);
    chk("rst_coef_data", bus.coef_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // mode 11, alternating halves, back-to-back
    words[0] = 32'h0888_007A; words[1] = 32'h007A_0888;
    words[2] = 32'h0888_007A; words[3] = 32'h007A_0888;
    launch(2'b11, 10'h010);
    stream(100, 0, -1);
    verify("eta16", 10'h010, 32'd2, 32'd12287, 32'd2, 32'd12287);
    for (int i = 1; i < NC; i++)
      if (i < wc_q.size()) chk("eta16_consecutive", wc_q[i], wc_q[0] + i);
    chk("idle_busy", busy, 0);

    // mode 00, negative
    for (int i = 0; i < NC; i++) words[i] = 32'h0003_0000;
    launch(2'b00, 10'h020);
    stream(100, 0, -1);
    verify("eta2_neg", 10'h020, 32'd12287, 32'd12287, 32'd12287, 32'd12287);

    // mode 00, positive, upper operand bits set
    words[0] = 32'h0000_0003; words[1] = 32'hFFFC_FFFF;
    words[2] = 32'h0000_0003; words[3] = 32'hFFFC_FFFF;
    launch(2'b00, 10'h030);
    stream(100, 0, -1);
    verify("eta2_pos", 10'h030, 32'd2, 32'd2, 32'd2, 32'd2);

    // write-side stall mid-stream
    words[0] = 32'h0888_007A; words[1] = 32'h007A_0888;
    words[2] = 32'h0888_007A; words[3] = 32'h007A_0888;
    launch(2'b11, 10'h010);
    stream(2, 3, -1);
    verify("stall", 10'h010, 32'd2, 32'd12287, 32'd2, 32'd12287);

    // address wrap
    launch(2'b11, 10'h3FE);
    stream(100, 0, -1);
    verify("wrap", 10'h3FE, 32'd2, 32'd12287, 32'd2, 32'd12287);

    // abort after two writes, then a fresh run
    launch(2'b11, 10'h100);
    stream(100, 0, 2);
    chk("abort_writes", wa_q.size(), 2);
    chk("abort_coef_valid", bus.coef_valid, 0);
    chk("abort_rnd_ready", bus.rnd_ready, 0);
    chk("abort_busy", busy, 0);
    step(); step(); step();
    chk("abort_no_done", dc_q.size(), 0);
    launch(2'b11, 10'h040);
    stream(100, 0, -1);
    verify("rerun", 10'h040, 32'd2, 32'd12287, 32'd2, 32'd12287);

    // asynchronous reset mid-run
    launch(2'b11, 10'h050);
    bus.rnd_valid = 1'b1; bus.rnd_data = 32'h0888_007A; bus.coef_ready = 1'b0;
    step();
    chk("pre_reset_coef_valid", bus.coef_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_coef_valid", bus.coef_valid, 0);
    chk("mid_rst_rnd_ready", bus.rnd_ready, 0);
    chk("mid_rst_coef_addr", bus.coef_addr, 0);
    chk("mid_rst_coef_data", bus.coef_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    bus.rnd_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
